// File: rtl/dist_sample_stats.sv
// Windowed min/max/sum/mean of a signed 32-bit sample stream, reported through a held valid/ready handshake.
// Optional macro DIST_STATS_SUMSQ_EN adds a stat_sumsq output (sum of squares over the window).
module dist_sample_stats #(
  parameter int WINDOW_LOG2 = 4,
  parameter int SUM_W       = 32 + WINDOW_LOG2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [31:0]            sample_in,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  input  logic                   stats_ready,
  output logic                   stats_valid,
  output logic [31:0]            stat_min,
  output logic [31:0]            stat_max,
  output logic [SUM_W-1:0]       stat_sum,
  output logic [31:0]            stat_mean,
  output logic [WINDOW_LOG2:0]   sample_count,
  output logic                   busy
`ifdef DIST_STATS_SUMSQ_EN
  ,
  output logic [64+WINDOW_LOG2-1:0] stat_sumsq
`endif
);

  localparam int N = 1 << WINDOW_LOG2;
  localparam logic [WINDOW_LOG2:0] CNT_FULL = (WINDOW_LOG2 + 1)'(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t                   state_q;
  logic signed [31:0]       samp;
  logic signed [31:0]       min_q, max_q, min_d, max_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d, samp_ext;
  logic [WINDOW_LOG2:0]     cnt_q, cnt_d;
  logic signed [31:0]       rmin_q, rmax_q, rmean_q;
  logic signed [SUM_W-1:0]  rsum_q;
  logic                     first, accept;

  assign samp         = sample_in;
  assign sample_ready = (state_q != REPORT) && !clear;
  assign accept       = sample_valid && sample_ready;
  assign first        = (state_q == IDLE);

  // In IDLE the incoming sample seeds the running values instead of merging into them.
  always_comb begin
    samp_ext = {{(SUM_W - 32){samp[31]}}, samp};
    min_d    = (!first && (min_q < samp)) ? min_q : samp;
    max_d    = (!first && (max_q > samp)) ? max_q : samp;
    sum_d    = (first ? '0 : sum_q) + samp_ext;
    cnt_d    = first ? (WINDOW_LOG2 + 1)'(1) : cnt_q + (WINDOW_LOG2 + 1)'(1);
  end

`ifdef DIST_STATS_SUMSQ_EN
  logic signed [63:0]          sq;
  logic [64+WINDOW_LOG2-1:0]   sumsq_q, sumsq_d, rsumsq_q;

  always_comb begin
    sq      = 64'(samp) * 64'(samp);
    sumsq_d = (first ? '0 : sumsq_q) + {{WINDOW_LOG2{1'b0}}, sq};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sumsq_q  <= '0;
      rsumsq_q <= '0;
    end else if (!clear && accept) begin
      sumsq_q <= sumsq_d;
      if (cnt_d == CNT_FULL) rsumsq_q <= sumsq_d;
    end
  end

  assign stat_sumsq = rsumsq_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      min_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      rmin_q  <= '0;
      rmax_q  <= '0;
      rsum_q  <= '0;
      rmean_q <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            min_q <= min_d;
            max_q <= max_d;
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            if (cnt_d == CNT_FULL) begin
              rmin_q  <= min_d;
              rmax_q  <= max_d;
              rsum_q  <= sum_d;
              rmean_q <= 32'(sum_d >>> WINDOW_LOG2);
              state_q <= REPORT;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        REPORT: begin
          if (stats_ready) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stats_valid  = (state_q == REPORT);
  assign busy         = (state_q != IDLE);
  assign sample_count = cnt_q;
  assign stat_min     = rmin_q;
  assign stat_max     = rmax_q;
  assign stat_sum     = rsum_q;
  assign stat_mean    = rmean_q;

endmodule

// File: tb/tb_dist_sample_stats.sv
// Bench for dist_sample_stats (WINDOW_LOG2=2): queue-based window model plus directed literal checks.
module tb_dist_sample_stats;
  localparam int W  = 2;
  localparam int N  = 1 << W;
  localparam int SW = 32 + W;

  logic              clk = 1'b0;
  logic              rst, clear, sample_valid, stats_ready;
  logic [31:0]       sample_in;
  logic              sample_ready, stats_valid, busy;
  logic [31:0]       stat_min, stat_max, stat_mean;
  logic [SW-1:0]     stat_sum;
  logic [W:0]        sample_count;
`ifdef DIST_STATS_SUMSQ_EN
  logic [64+W-1:0]   stat_sumsq;
`endif

  dist_sample_stats #(.WINDOW_LOG2(W)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .stats_ready(stats_ready), .stats_valid(stats_valid),
    .stat_min(stat_min), .stat_max(stat_max), .stat_sum(stat_sum), .stat_mean(stat_mean),
    .sample_count(sample_count), .busy(busy)
`ifdef DIST_STATS_SUMSQ_EN
    , .stat_sumsq(stat_sumsq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the accepted samples of the current window, and the last reported statistics.
  int              q[$];
  bit              m_rep;
  int              m_min, m_max, m_mean;
  longint          m_sum;
  logic [64+W-1:0] m_sumsq;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_rep = 0; m_min = 0; m_max = 0; m_mean = 0; m_sum = 0; m_sumsq = '0;
    end else if (clear) begin
      q.delete();
      m_rep = 0;
    end else if (m_rep) begin
      if (stats_ready) begin
        m_rep = 0;
        q.delete();
      end
    end else if (sample_valid) begin
      q.push_back(int'(sample_in));
      if (q.size() == N) begin
        m_min = q[0]; m_max = q[0]; m_sum = 0; m_sumsq = '0;
        foreach (q[i]) begin
          if (q[i] < m_min) m_min = q[i];
          if (q[i] > m_max) m_max = q[i];
          m_sum   += longint'(q[i]);
          m_sumsq += (64 + W)'(longint'(q[i]) * longint'(q[i]));
        end
        m_mean = int'(m_sum >>> W);
        m_rep  = 1;
      end
    end
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("sample_ready", longint'(sample_ready), longint'(!m_rep && !clear));
    chk("stats_valid", longint'(stats_valid), longint'(m_rep));
    chk("busy", longint'(busy), longint'(q.size() != 0));
    chk("sample_count", longint'(sample_count), longint'(q.size()));
    chk("stat_min", longint'($signed(stat_min)), longint'(m_min));
    chk("stat_max", longint'($signed(stat_max)), longint'(m_max));
    chk("stat_sum", longint'($signed(stat_sum)), m_sum);
    chk("stat_mean", longint'($signed(stat_mean)), longint'(m_mean));
`ifdef DIST_STATS_SUMSQ_EN
    checks++;
    if (stat_sumsq !== m_sumsq) begin
      errors++;
      $display("FAIL stat_sumsq: got %0d expected %0d", stat_sumsq, m_sumsq);
    end
`endif
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int s, input bit c, input bit r);
    sample_valid = v;
    sample_in    = s;
    clear        = c;
    stats_ready  = r;
    cycle();
  endtask

  task automatic window(input int a, input int b, input int c, input int d);
    drive(1, a, 0, 0);
    drive(1, b, 0, 0);
    drive(1, c, 0, 0);
    drive(1, d, 0, 0);
  endtask

  initial begin
    rst = 1; clear = 0; sample_valid = 0; sample_in = '0; stats_ready = 0;
    cycle();
    cycle();
    chk("reset_ready", longint'(sample_ready), 1);
    chk("reset_valid", longint'(stats_valid), 0);
    rst = 0;

    window(10, -3, 7, 2);
    chk("w1_valid", longint'(stats_valid), 1);
    chk("w1_min", longint'($signed(stat_min)), -3);
    chk("w1_max", longint'($signed(stat_max)), 10);
    chk("w1_sum", longint'($signed(stat_sum)), 16);
    chk("w1_mean", longint'($signed(stat_mean)), 4);
    chk("w1_model_sum", m_sum, 16);
    repeat (5) drive(1, int'($urandom), 0, 0);
    chk("hold_sum", longint'($signed(stat_sum)), 16);
    chk("hold_count", longint'(sample_count), 4);
    chk("hold_ready", longint'(sample_ready), 0);
    drive(0, 0, 0, 1);
    chk("rel_ready", longint'(sample_ready), 1);
    chk("rel_count", longint'(sample_count), 0);
    chk("rel_valid", longint'(stats_valid), 0);

    window(-1, -1, -1, -2);
    chk("w2_sum", longint'($signed(stat_sum)), -5);
    chk("w2_mean", longint'($signed(stat_mean)), -2);
    chk("w2_min", longint'($signed(stat_min)), -2);
    chk("w2_max", longint'($signed(stat_max)), -1);
    chk("w2_model_mean", longint'(m_mean), -2);
    drive(0, 0, 0, 1);

    window(32'h7fffffff, 32'h7fffffff, 32'h7fffffff, 32'h7fffffff);
    chk("w3_sum", longint'($signed(stat_sum)), 64'sd8589934588);
    chk("w3_mean", longint'($signed(stat_mean)), 64'sd2147483647);
    drive(0, 0, 0, 1);

    window(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
    chk("w4_sum", longint'($signed(stat_sum)), -64'sd8589934592);
    chk("w4_mean", longint'($signed(stat_mean)), -64'sd2147483648);
    drive(0, 0, 0, 1);

    drive(1, 1, 0, 0);
    drive(1, 2, 0, 0);
    drive(1, 99, 1, 0);
    chk("clr_count", longint'(sample_count), 0);
    chk("clr_busy", longint'(busy), 0);
    chk("clr_sum_kept", longint'($signed(stat_sum)), -64'sd8589934592);
    clear = 0;
    window(5, 5, 5, 5);
    chk("w5_sum", longint'($signed(stat_sum)), 20);
    chk("w5_mean", longint'($signed(stat_mean)), 5);
    drive(0, 0, 0, 1);

    window(3, -4, 0, 1);
    chk("w6_min", longint'($signed(stat_min)), -4);
    chk("w6_max", longint'($signed(stat_max)), 3);
`ifdef DIST_STATS_SUMSQ_EN
    chk("w6_sumsq", longint'(stat_sumsq), 26);
`endif
    drive(0, 0, 0, 1);

    drive(1, 7, 0, 0);
    drive(1, 8, 0, 0);
    sample_valid = 0;
    #2 rst = 1;
    #1;
    chk("arst_count", longint'(sample_count), 0);
    chk("arst_busy", longint'(busy), 0);
    chk("arst_sum", longint'($signed(stat_sum)), 0);
    chk("arst_max", longint'($signed(stat_max)), 0);
    chk("arst_ready", longint'(sample_ready), 1);
    cycle();
    rst = 0;

    for (int i = 0; i < 500; i++) begin
      int s;
      case ($urandom_range(0, 3))
        0: s = int'($urandom);
        1: s = 32'h7fffffff;
        2: s = 32'h80000000;
        default: s = int'($urandom_range(0, 40)) - 20;
      endcase
      drive($urandom_range(0, 99) < 70, s, $urandom_range(0, 99) < 3, $urandom_range(0, 1) == 1);
    end
    drive(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dist_sample_stats.md
Name: dist_sample_stats

Overview:
- Downstream consumer of the distribution-function stage's int sample outputs (uniform/normal/exponential/etc.).
- Collects a fixed window of signed 32-bit samples through a valid/ready handshake.
- Reports min, max, sum and mean for the window through a second, held valid/ready handshake.
- Used to sanity-check distribution parameters in simulation without dumping raw streams.

Parameters:
- WINDOW_LOG2, 4: window length is 2**WINDOW_LOG2 samples; legal range 1..8.
- SUM_W, 32+WINDOW_LOG2: sum accumulator width, signed; must not be overridden smaller.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- clear  input  1  synchronous abort; discards the partial window and returns to IDLE
- sample_in  input  32  signed int sample from the distribution stage
- sample_valid  input  1  sample_in is valid
- sample_ready  output  1  block accepts a sample this cycle
- stats_ready  input  1  consumer accepts the report
- stats_valid  output  1  report outputs are valid and held
- stat_min  output  32  signed minimum of the window
- stat_max  output  32  signed maximum of the window
- stat_sum  output  SUM_W  signed sum of the window
- stat_mean  output  32  signed stat_sum >>> WINDOW_LOG2 (arithmetic, floor toward -inf)
- sample_count  output  WINDOW_LOG2+1  samples accepted in the current window
- busy  output  1  high in ACCUM or REPORT

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0 except sample_ready=1. stat_min=0 and stat_max=0 until the first report.
- Accept event: sample_valid && sample_ready at the rising clk edge.
- sample_ready = (state != REPORT) && !clear.
- Internal running min/max/sum and count; the reported stat_* update only on entry to REPORT.
- IDLE:
  - On accept: min=max=sample, sum=sign-extended sample, count=1, go to ACCUM.
  - With WINDOW_LOG2 legal, a window is always >1 sample.
- ACCUM:
  - On accept: min=signed-min(min,sample), max=signed-max(max,sample), sum+=sext(sample), count+=1.
  - When the accepted sample makes count == 2**WINDOW_LOG2: latch stat_min/max/sum/mean from the post-update values and go to REPORT.
  - Last-sample latency: stats_valid rises the cycle after the last accept.
- REPORT:
  - stats_valid=1; stat_* stable while stats_valid && !stats_ready.
  - On stats_ready: stats_valid=0, count=0, go to IDLE. sample_ready rises in the same cycle stats_valid falls.
  - No back-to-back overlap: samples are not accepted during REPORT.
- sample_count: increments on accept, reads 2**WINDOW_LOG2 in REPORT, returns to 0 on leaving REPORT.
- Arithmetic:
  - All comparisons signed.
  - SUM_W sized so 2**WINDOW_LOG2 extreme samples never overflow. No saturation or wrap logic is required or permitted.
  - Mean is the low 32 bits of the arithmetic shift; it always fits.
- clear (sync):
  - Any state goes to IDLE, count=0, stats_valid=0.
  - Reported stat_* keep their last reported values.
  - A sample presented with clear high is not accepted.
  - clear has priority over stats_ready and over accept.
- rst mid-window or mid-report: immediate return to reset values; the partial window is lost.

Optional Feature:
- Macro: DIST_STATS_SUMSQ_EN.
- Defined:
  - Adds output stat_sumsq, width 64+WINDOW_LOG2, unsigned: sum of sample*sample over the window (64-bit signed product, non-negative).
  - Accumulated and latched exactly like stat_sum; 0 at reset; cleared by clear; held in REPORT.
  - The multiply may be registered with one extra pipeline stage. If so, REPORT entry delays one cycle so all stats latch together.
- Undefined: port absent; no multiplier; base timing exactly as above.

Test Plan:
- WINDOW_LOG2=2; samples 10,-3,7,2 with valid every cycle -> stats_valid the cycle after the 4th accept; min=-3, max=10, sum=16, mean=4; sample_ready=0 until stats_ready.
- Samples -1,-1,-1,-2 -> sum=-5, mean=-2 (floor), min=-2, max=-1.
- Four samples of 2147483647 -> sum=8589934588, mean=2147483647. Four samples of -2147483648 -> sum=-8589934592, mean=-2147483648. No overflow in either case.
- Hold stats_ready=0 for 5 cycles in REPORT while driving sample_valid=1 -> outputs stable, no accepts, sample_count=4. stats_ready=1 -> next cycle IDLE, sample_ready=1, sample_count=0.
- Accept 2 samples, then assert clear together with sample_valid -> sample not accepted, IDLE, sample_count=0, stat_* unchanged. Next window of 5,5,5,5 -> sum=20, mean=5.
- Assert rst asynchronously mid-ACCUM, between clock edges -> outputs go to reset values immediately. With DIST_STATS_SUMSQ_EN: window 3,-4,0,1 -> stat_sumsq=26.
